// File: rtl/seven_segment_capture.sv
// Purpose : snoops a multiplexed seven-segment bus and decodes each stable digit back to a hex nibble.
// Latency : a capture is visible STABLE_CYCLES+1 edges after the first edge that sampled the new pair.
// Backpr. : none; a free-running observer that never stalls the bus it watches.
//
// Ports
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   anodes_in     one-hot digit select (bit i = digit i)
//   seg_in        segments {a,b,c,d,e,f,g,dp}, active-high
//   clear         zeroes digits/digit_valid/dp_out (a same-cycle capture still lands)
//   digits        captured nibbles, digits[4i+3:4i] = digit i
//   digit_valid   digit i holds a decoded value
//   dp_out        captured decimal point per digit
//   cap_strobe    one-cycle pulse per capture; cap_index holds the digit of the last one
//   err_pattern   one-cycle pulse: captured segment pattern not a hex glyph
//   err_anode     one-cycle pulse: stable anode select had more than one bit set
module seven_segment_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  anodes_in,
    input  logic [7:0]  seg_in,
    input  logic        clear,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  dp_out,
    output logic        cap_strobe,
    output logic [2:0]  cap_index,
    output logic        err_pattern,
    output logic        err_anode
);

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

    localparam logic [7:0] CNT_MATCH = 8'(STABLE_CYCLES - 1);

    logic [15:0] r;
    logic [15:0] r_d;
    logic [7:0]  cnt;
    state_t      state;
    state_t      state_nxt;
    logic        same;
    logic        fire;
    logic [2:0]  idx;
    logic [3:0]  nbits;
    logic        one_hot;
    logic        multi_hot;
    logic        do_cap;
    logic        do_err_anode;
    logic [4:0]  dec;
    logic        hit;

    // Returns {hit, value}; the dp bit is not part of the glyph.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h7E:   res = 5'h10;
            7'h30:   res = 5'h11;
            7'h6D:   res = 5'h12;
            7'h79:   res = 5'h13;
            7'h33:   res = 5'h14;
            7'h5B:   res = 5'h15;
            7'h5F:   res = 5'h16;
            7'h70:   res = 5'h17;
            7'h7F:   res = 5'h18;
            7'h7B:   res = 5'h19;
            7'h77:   res = 5'h1A;
            7'h1F:   res = 5'h1B;
            7'h4E:   res = 5'h1C;
            7'h3D:   res = 5'h1D;
            7'h4F:   res = 5'h1E;
            7'h47:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    assign same = (r == r_d);
    assign dec  = decode(r[7:1]);
    assign hit  = dec[4];

    // Next state: any change in the sampled pair reopens the window; in
    // SETTLE the window fires once the counter has seen enough equal pairs.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        if (!same) begin
            state_nxt = SETTLE;
        end else if (state == SETTLE && cnt == CNT_MATCH) begin
            fire      = 1'b1;
            state_nxt = HOLD;
        end
    end

    // Anode classification of the stable sample.
    always_comb begin
        idx   = 3'd0;
        nbits = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[8+i]) begin
                idx   = 3'(i);
                nbits = nbits + 4'd1;
            end
        end
    end

    assign one_hot      = (nbits == 4'd1);
    assign multi_hot    = (nbits > 4'd1);
    assign do_cap       = fire && one_hot;
    assign do_err_anode = fire && multi_hot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r           <= '0;
            r_d         <= '0;
            cnt         <= '0;
            state       <= SETTLE;
            digits      <= '0;
            digit_valid <= '0;
            dp_out      <= '0;
            cap_strobe  <= 1'b0;
            cap_index   <= '0;
            err_pattern <= 1'b0;
            err_anode   <= 1'b0;
        end else begin
            r     <= {anodes_in, seg_in};
            r_d   <= r;
            state <= state_nxt;

            if (!same) begin
                cnt <= '0;
            end else if (cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end

            cap_strobe  <= do_cap;
            err_pattern <= do_cap && !hit;
            err_anode   <= do_err_anode;
            if (do_cap) begin
                cap_index <= idx;
            end

            // The digit being captured wins over clear; all others follow clear.
            for (int i = 0; i < 8; i++) begin
                if (do_cap && idx == 3'(i)) begin
                    digits[4*i +: 4] <= hit ? dec[3:0] : 4'h0;
                    digit_valid[i]   <= hit;
                    dp_out[i]        <= r[0];
                end else if (clear) begin
                    digits[4*i +: 4] <= 4'h0;
                    digit_valid[i]   <= 1'b0;
                    dp_out[i]        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Purpose : directed bench for seven_segment_capture with a run-length reference model.
// Latency : model predicts captures STABLE+1 edges after a new value is first sampled.
// Backpr. : n/a.
module tb_seven_segment_capture;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  anodes_in;
    logic [7:0]  seg_in;
    logic        clear;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic [7:0]  dp_out;
    logic        cap_strobe;
    logic [2:0]  cap_index;
    logic        err_pattern;
    logic        err_anode;

    always #5 clk = ~clk;

    seven_segment_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anodes_in   (anodes_in),
        .seg_in      (seg_in),
        .clear       (clear),
        .digits      (digits),
        .digit_valid (digit_valid),
        .dp_out      (dp_out),
        .cap_strobe  (cap_strobe),
        .cap_index   (cap_index),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Glyph table, index = hex value.
    logic [6:0] enc [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: tracks how long the sampled pair has stayed the same
    // and fires once per run when it has been seen STABLE+1 times in a row.
    logic [31:0] m_digits = '0;
    logic [7:0]  m_valid  = '0;
    logic [7:0]  m_dp     = '0;
    logic        m_strobe = 1'b0;
    logic [2:0]  m_idx    = '0;
    logic        m_errp   = 1'b0;
    logic        m_erra   = 1'b0;
    logic [15:0] cur      = '0;
    int          run_len  = 0;
    bit          done     = 0;
    int          cap_i;
    int          nb;
    int          found;
    logic [7:0]  ma;
    logic [7:0]  ms;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (!rst_n) begin
            m_digits = '0; m_valid = '0; m_dp = '0;
            m_strobe = 0; m_idx = '0; m_errp = 0; m_erra = 0;
            cur = '0; run_len = 2; done = 0;
        end else begin
            m_strobe = 0; m_errp = 0; m_erra = 0;
            cap_i = -1;
            if (!done && run_len >= STABLE + 1) begin
                done = 1;
                ma = cur[15:8];
                ms = cur[7:0];
                nb = 0;
                for (int j = 0; j < 8; j++) if (ma[j]) begin nb++; cap_i = j; end
                if (nb == 1) begin
                    m_strobe = 1;
                    m_idx = 3'(cap_i);
                    m_dp[cap_i] = ms[0];
                    found = -1;
                    for (int v = 0; v < 16; v++) if (enc[v] == ms[7:1]) found = v;
                    if (found >= 0) begin
                        m_digits[4*cap_i +: 4] = 4'(found);
                        m_valid[cap_i] = 1'b1;
                    end else begin
                        m_digits[4*cap_i +: 4] = 4'h0;
                        m_valid[cap_i] = 1'b0;
                        m_errp = 1;
                    end
                end else begin
                    cap_i = -1;
                    if (nb > 1) m_erra = 1;
                end
            end
            if (clear) begin
                for (int j = 0; j < 8; j++) begin
                    if (j != cap_i) begin
                        m_digits[4*j +: 4] = 4'h0;
                        m_valid[j] = 1'b0;
                        m_dp[j] = 1'b0;
                    end
                end
            end
            if ({anodes_in, seg_in} == cur) begin
                if (run_len < 1000) run_len++;
            end else begin
                cur = {anodes_in, seg_in};
                run_len = 1;
                done = 0;
            end
        end
    end

    // Per-cycle comparison and pulse bookkeeping, away from the active edge.
    int strobes = 0;
    int errps   = 0;
    int erras   = 0;
    int last_strobe = -1;

    always @(negedge clk) begin
        if (started) begin
            chk("cycle", {digits, digit_valid, dp_out, cap_strobe, cap_index, err_pattern, err_anode},
                {m_digits, m_valid, m_dp, m_strobe, m_idx, m_errp, m_erra});
            if (cap_strobe === 1'b1) begin
                strobes++;
                last_strobe = cyc;
            end
            if (err_pattern === 1'b1) errps++;
            if (err_anode === 1'b1) erras++;
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] s, input logic c,
                         input logic rn, input int n);
        anodes_in = a;
        seg_in    = s;
        clear     = c;
        rst_n     = rn;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s0;
    int p0;
    int a0;
    int e0;
    logic [7:0] sv;

    initial begin
        // 1: reset with random inputs, then idle.
        drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1);
        drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1);
        chk("rst_digits", digits, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_pulses", {cap_strobe, err_pattern, err_anode, cap_index, dp_out}, 0);
        s0 = strobes;
        drive(8'h00, 8'h00, 1'b0, 1'b1, 10);
        chk("idle_no_strobe", strobes - s0, 0);

        // 2: digit 2 shows "2".
        s0 = strobes;
        e0 = cyc + 1;
        drive(8'h04, 8'hDA, 1'b0, 1'b1, 10);
        chk("t2_strobes", strobes - s0, 1);
        chk("t2_latency", last_strobe, e0 + 5);
        chk("t2_index", cap_index, 3'd2);
        chk("t2_nibble", digits[11:8], 4'h2);
        chk("t2_valid", digit_valid, 8'h04);
        chk("t2_model_valid", m_valid, 8'h04);

        // 3: short-lived 8 is ignored, then 0 captured.
        s0 = strobes;
        drive(8'h01, 8'hFE, 1'b0, 1'b1, 3);
        e0 = cyc + 1;
        drive(8'h01, 8'hFC, 1'b0, 1'b1, 8);
        chk("t3_strobes", strobes - s0, 1);
        chk("t3_latency", last_strobe, e0 + 5);
        chk("t3_index", cap_index, 3'd0);
        chk("t3_digits", digits, 32'h0000_0200);
        chk("t3_valid", digit_valid, 8'h05);

        // 4: blank pattern is not a glyph.
        s0 = strobes;
        p0 = errps;
        drive(8'h80, 8'h00, 1'b0, 1'b1, 8);
        chk("t4_strobes", strobes - s0, 1);
        chk("t4_errp", errps - p0, 1);
        chk("t4_valid", digit_valid, 8'h05);
        chk("t4_nibble", digits[31:28], 4'h0);
        chk("t4_index", cap_index, 3'd7);

        // 5: two anodes at once.
        s0 = strobes;
        a0 = erras;
        drive(8'h03, 8'h60, 1'b0, 1'b1, 8);
        chk("t5_erra", erras - a0, 1);
        chk("t5_strobes", strobes - s0, 0);
        chk("t5_digits", digits, 32'h0000_0200);
        chk("t5_valid", digit_valid, 8'h05);

        // 6: full scan, dp on odd digits.
        for (int i = 0; i < 8; i++) begin
            sv = {enc[i], i[0]};
            drive(8'(1 << i), sv, 1'b0, 1'b1, 6);
        end
        chk("t6_digits", digits, 32'h7654_3210);
        chk("t6_valid", digit_valid, 8'hFF);
        chk("t6_dp", dp_out, 8'hAA);
        chk("t6_model_digits", m_digits, 32'h7654_3210);
        chk("t6_model_dp", m_dp, 8'hAA);

        // Clear coincides with the capture of digit 3.
        drive(8'h08, 8'hF2, 1'b0, 1'b1, 5);
        drive(8'h08, 8'hF2, 1'b1, 1'b1, 1);
        chk("clr_valid", digit_valid, 8'h08);
        chk("clr_digits", digits, 32'h0000_3000);
        chk("clr_dp", dp_out, 8'h00);
        chk("clr_index", cap_index, 3'd3);
        chk("clr_model_valid", m_valid, 8'h08);

        // Reset in the middle of a settle window aborts it.
        drive(8'h20, 8'hB7, 1'b0, 1'b1, 3);
        s0 = strobes;
        drive(8'h20, 8'hB7, 1'b0, 1'b0, 1);
        drive(8'h00, 8'h00, 1'b0, 1'b1, 8);
        chk("rst_mid_strobes", strobes - s0, 0);
        chk("rst_mid_valid", digit_valid, 8'h00);
        chk("rst_mid_index", cap_index, 3'd0);

        // Capture works again after reset.
        drive(8'h20, 8'hB7, 1'b0, 1'b1, 8);
        chk("post_digits", digits, 32'h0050_0000);
        chk("post_valid", digit_valid, 8'h20);
        chk("post_dp", dp_out, 8'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
